// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative multiply/divide unit with HI/LO registers (MULT/MULTU/
//            DIV/DIVU in WIDTH+2 cycles, MTHI/MTLO writes).
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int            CW     = $clog2(WIDTH);
    localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CW-1:0]       r_cnt;
    logic                r_div;
    logic                r_neg_q;
    logic                r_neg_r;
    logic                r_bzero;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [2*WIDTH-1:0]  r_acc;

    logic                w_accept;
    logic                w_sa;
    logic                w_sb;
    logic [WIDTH-1:0]    w_mag_a;
    logic [WIDTH-1:0]    w_mag_b;
    logic [WIDTH:0]      w_add;
    logic [WIDTH:0]      w_shift;
    logic [WIDTH:0]      w_diff;
    logic [2*WIDTH-1:0]  w_mul_next;
    logic [2*WIDTH-1:0]  w_div_next;
    logic [2*WIDTH-1:0]  w_prod;
    logic [WIDTH-1:0]    w_quo;
    logic [WIDTH-1:0]    w_rem;
    logic [WIDTH-1:0]    w_a_orig;

    assign busy     = (r_state != S_IDLE);
    assign w_accept = (r_state == S_IDLE) && start;

    // op[0] selects the signed variants; magnitudes feed the unsigned core
    assign w_sa    = op[0] & src_a[WIDTH-1];
    assign w_sb    = op[0] & src_b[WIDTH-1];
    assign w_mag_a = w_sa ? -src_a : src_a;
    assign w_mag_b = w_sb ? -src_b : src_b;

    // Multiply: acc = {partial product, remaining multiplier bits}
    assign w_add      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
    assign w_mul_next = {w_add, r_acc[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend shifting into quotient}
    assign w_shift    = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff     = w_shift - {1'b0, r_b};
    assign w_div_next = w_diff[WIDTH] ? {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                      : {w_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

    assign w_prod   = r_neg_q ? -r_acc : r_acc;
    assign w_quo    = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem    = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    assign w_a_orig = r_neg_r ? -r_a : r_a;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_CALC;
            S_CALC:  if (r_cnt == c_last) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_bzero <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_div   <= op[1];
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_bzero <= (src_b == '0);
            r_a     <= w_mag_a;
            r_b     <= w_mag_b;
            r_acc   <= {{WIDTH{1'b0}}, (op[1] ? w_mag_a : w_mag_b)};
        end else if (r_state == S_CALC) begin
            r_cnt <= r_cnt + 1'b1;
            r_acc <= r_div ? w_div_next : w_mul_next;
        end
    end

    // Result write in FIX has priority; MTHI/MTLO only land while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= (r_state == S_FIX);
            if (r_state == S_FIX) begin
                if (!r_div) begin
                    {hi, lo} <= w_prod;
                end else if (r_bzero) begin
                    hi <= w_a_orig;
                    lo <= '1;
                end else begin
                    hi <= w_rem;
                    lo <= w_quo;
                end
            end else if (!busy) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Self-checking bench for muldiv_unit against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst, start, hi_we, lo_we, busy, done;
    logic [1:0]  op;
    logic [31:0] src_a, src_b, wdata, hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .hi_we(hi_we), .lo_we(lo_we),
        .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: {hi, lo} from plain 64-bit arithmetic
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'd0: r = {32'b0, a} * {32'b0, b};
            2'd1: r = 64'(sa * sb);
            2'd2: r = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            default: r = (b == 0) ? {a, 32'hFFFFFFFF} : {32'(sa % sb), 32'(sa / sb)};
        endcase
        return r;
    endfunction

    // Starts an op in the current (idle) cycle; returns in its done cycle
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input bit disturb, input bit mt);
        int n;
        bit busy_bad;
        op = o; src_a = a; src_b = b; start = 1'b1;
        if (mt) begin hi_we = 1'b1; wdata = 32'hDEADBEEF; end
        tick();
        start = 1'b0; hi_we = 1'b0;
        src_a = $urandom; src_b = $urandom; op = 2'($urandom);
        if (mt) check("mthi_with_start", {32'b0, hi}, 64'hDEADBEEF);
        n = 1;
        busy_bad = 1'b0;
        while (!done && n < 100) begin
            if (!busy) busy_bad = 1'b1;
            if (disturb && n == 5) begin
                start = 1'b1; lo_we = 1'b1; hi_we = 1'b1; wdata = $urandom;
            end
            tick();
            start = 1'b0; lo_we = 1'b0; hi_we = 1'b0;
            n++;
        end
        check("latency", 64'(n), 64'd34);
        check("busy_during_op", {63'b0, busy_bad}, 64'd0);
        check("busy_in_done", {63'b0, busy}, 64'd0);
        check("result", {hi, lo}, exp);
    endtask

    initial begin
        bit seen;
        logic [1:0]  o;
        logic [31:0] a, b;
        rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'd0; src_a = '0; src_b = '0; wdata = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);

        hi_we = 1'b1; wdata = 32'h1234; tick(); hi_we = 1'b0;
        check("mthi", {32'b0, hi}, 64'h1234);
        lo_we = 1'b1; wdata = 32'h5678; tick(); lo_we = 1'b0;
        check("mtlo", {32'b0, lo}, 64'h5678);

        do_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0, 1'b0);
        tick();
        check("done_pulse", {63'b0, done}, 64'd0);

        do_op(2'd1, 32'hFFFFFFFD, 32'd7,        64'hFFFFFFFF_FFFFFFEB, 1'b0, 1'b0);
        do_op(2'd1, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0, 1'b0);
        do_op(2'd3, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 1'b0, 1'b0);
        do_op(2'd2, 32'd100,      32'd7,        64'h00000002_0000000E, 1'b0, 1'b0);
        do_op(2'd3, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 1'b0);
        do_op(2'd2, 32'd5,        32'd0,        64'h00000005_FFFFFFFF, 1'b1, 1'b0);
        do_op(2'd3, 32'hFFFFFFF7, 32'd0,        64'hFFFFFFF7_FFFFFFFF, 1'b0, 1'b1);
        tick();

        // Reset in the middle of a divide: result discarded, no done
        op = 2'd3; src_a = 32'hFFFFFF00; src_b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("midop_rst_busy", {63'b0, busy}, 64'd0);
        check("midop_rst_hilo", {hi, lo}, 64'd0);
        seen = 1'b0;
        repeat (40) begin
            if (done) seen = 1'b1;
            tick();
        end
        check("no_done_after_rst", {63'b0, seen}, 64'd0);

        // Random ops, chained back-to-back in each done cycle
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: a = 32'h80000000;
                3: b = 32'hFFFFFFFF;
                default: ;
            endcase
            do_op(o, a, b, model(o, a, b), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end
        tick();
        check("final_done_pulse", {63'b0, done}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
